// File: rtl/rapid_pkg.sv
// Shared types for the RAPID pipeline hazard logic: instruction hazard classes
// and the scoreboard slot record tracked for the EX and MEM stages.
package rapid_pkg;

  localparam int SB_RD_W = 8;

  typedef enum logic [1:0] {
    HC_ALU  = 2'd0,
    HC_LOAD = 2'd1,
    HC_LONG = 2'd2,
    HC_RSVD = 2'd3
  } hazard_class_e;

  // rd is sized for the largest register file we expect; indices are zero-extended
  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               is_load;
  } sb_slot_s;

endpackage

// File: rtl/rapid_hazard_scoreboard.sv
// Hazard scoreboard for RAPID: decode stall, registered EX forward selects and
// tracking of outstanding long-latency (mul/div/coprocessor) destinations.
module rapid_hazard_scoreboard
  import rapid_pkg::*;
#(
  parameter int NUM_REGS       = 32,
  parameter int REG_W          = $clog2(NUM_REGS),
  parameter int MAX_LONG       = 4,
  parameter bit LOAD_USE_STALL = 1'b1,
  parameter int CNT_W          = $clog2(MAX_LONG + 1)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_advance,
  input  logic                i_flush,
  input  logic                i_de_valid,
  input  logic [REG_W-1:0]    i_de_rs1,
  input  logic                i_de_rs1_used,
  input  logic [REG_W-1:0]    i_de_rs2,
  input  logic                i_de_rs2_used,
  input  logic [REG_W-1:0]    i_de_rd,
  input  logic                i_de_rd_we,
  input  logic [1:0]          i_de_class,
  input  logic                i_wb_valid,
  input  logic [REG_W-1:0]    i_wb_rd,
  output logic                o_stall,
  output logic                o_issue,
  output logic                o_ex_fwd_rs1,
  output logic                o_ex_fwd_rs2,
  output logic [NUM_REGS-1:0] o_long_busy,
  output logic [CNT_W-1:0]    o_long_count,
  output logic                o_wb_err
);

  sb_slot_s            r_exSlot;
  sb_slot_s            r_memSlot;
  logic                r_fwdRs1;
  logic                r_fwdRs2;
  logic [NUM_REGS-1:0] r_longBusy;
  logic [CNT_W-1:0]    r_longCount;
  logic                r_wbErr;

  hazard_class_e       w_class;
  logic [NUM_REGS-1:0] w_busyEff;
  logic [1:0]          w_src1;
  logic [1:0]          w_src2;
  logic                w_rdNonZero;
  logic                w_waw;
  logic                w_full;
  logic                w_longSet;
  logic                w_wbOk;
  sb_slot_s            w_nextSlot;
  logic                w_unused;

  // Per-source check: bit 1 = stall contribution, bit 0 = hit on the EX-slot producer
  function automatic logic [1:0] srcCheck(input logic used, input logic [REG_W-1:0] rs,
                                          input logic [NUM_REGS-1:0] busyEff,
                                          input sb_slot_s ex);
    logic srcMatch;
    logic exHit;
    srcMatch = used && (rs != '0);
    exHit    = srcMatch && ex.valid && (ex.rd[REG_W-1:0] == rs);
    srcCheck = {(srcMatch && busyEff[rs]) || (exHit && ex.is_load && LOAD_USE_STALL), exHit};
  endfunction

  assign w_class = hazard_class_e'(i_de_class);

  // A long result written back this cycle is visible through the write-first register file
  assign w_busyEff = r_longBusy & ~(i_wb_valid ? (NUM_REGS'(1) << i_wb_rd) : '0);

  assign w_src1      = srcCheck(i_de_rs1_used, i_de_rs1, w_busyEff, r_exSlot);
  assign w_src2      = srcCheck(i_de_rs2_used, i_de_rs2, w_busyEff, r_exSlot);
  assign w_rdNonZero = (i_de_rd != '0);
  assign w_waw       = i_de_rd_we && r_longBusy[i_de_rd];
  assign w_full      = (w_class == HC_LONG) && i_de_rd_we && (r_longCount == CNT_W'(MAX_LONG));

  assign o_stall = i_de_valid && !i_flush && (w_src1[1] || w_src2[1] || w_waw || w_full);
  assign o_issue = i_de_valid && !o_stall && !i_flush && i_advance;

  assign w_longSet = o_issue && (w_class == HC_LONG) && i_de_rd_we && w_rdNonZero;
  assign w_wbOk    = i_wb_valid && (i_wb_rd != '0) && r_longBusy[i_wb_rd];

  always_comb begin
    w_nextSlot = '0;
    if (o_issue && i_de_rd_we && w_rdNonZero && (w_class != HC_LONG)) begin
      w_nextSlot.valid   = 1'b1;
      w_nextSlot.rd      = SB_RD_W'(i_de_rd);
      w_nextSlot.is_load = (w_class == HC_LOAD);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_exSlot  <= '0;
      r_memSlot <= '0;
      r_fwdRs1  <= 1'b0;
      r_fwdRs2  <= 1'b0;
    end else if (i_advance) begin
      r_memSlot <= r_exSlot;
      r_exSlot  <= w_nextSlot;
      r_fwdRs1  <= o_issue && w_src1[0];
      r_fwdRs2  <= o_issue && w_src2[0];
    end
  end

  // Long tracking runs every cycle; writebacks do not wait for the pipeline to advance
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_longBusy  <= '0;
      r_longCount <= '0;
      r_wbErr     <= 1'b0;
    end else begin
      r_longBusy  <= (r_longBusy & ~(w_wbOk ? (NUM_REGS'(1) << i_wb_rd) : '0))
                   | (w_longSet ? (NUM_REGS'(1) << i_de_rd) : '0);
      r_longCount <= r_longCount + CNT_W'(w_longSet) - CNT_W'(w_wbOk);
      if (i_wb_valid && !w_wbOk) begin
        r_wbErr <= 1'b1;
      end
    end
  end

  assign o_ex_fwd_rs1 = r_fwdRs1;
  assign o_ex_fwd_rs2 = r_fwdRs2;
  assign o_long_busy  = r_longBusy;
  assign o_long_count = r_longCount;
  assign o_wb_err     = r_wbErr;

  // MEM slot is kept for visibility only; upper rd bits are padding
  assign w_unused = ^{r_memSlot, r_exSlot.rd};

endmodule

// File: tb/tb_rapid_hazard_scoreboard.sv
// Randomised and directed bench for rapid_hazard_scoreboard; two instances
// (load-use stalling on and off) are checked against a behavioural model.
module tb_rapid_hazard_scoreboard;

  localparam int NUM_REGS = 32;
  localparam int REG_W    = 5;
  localparam int MAX_LONG = 4;
  localparam int CNT_W    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             advance, flush, deValid, deRs1Used, deRs2Used, deRdWe, wbValid;
  logic [REG_W-1:0] deRs1, deRs2, deRd, wbRd;
  logic [1:0]       deClass;

  logic                oStall[2], oIssue[2], oFwd1[2], oFwd2[2], oErr[2];
  logic [NUM_REGS-1:0] oBusy[2];
  logic [CNT_W-1:0]    oCount[2];

  int nChecks = 0;
  int nFails  = 0;

  bit mBusy[2][NUM_REGS];
  int mCnt[2];
  int mExRd[2];
  bit mErr[2], mExValid[2], mExLoad[2], mFwd1[2], mFwd2[2];

  always #5 clk = ~clk;

  rapid_hazard_scoreboard #(.NUM_REGS(NUM_REGS), .MAX_LONG(MAX_LONG), .LOAD_USE_STALL(1'b1)) dutA (
    .i_clk(clk), .i_reset(rst), .i_advance(advance), .i_flush(flush), .i_de_valid(deValid),
    .i_de_rs1(deRs1), .i_de_rs1_used(deRs1Used), .i_de_rs2(deRs2), .i_de_rs2_used(deRs2Used),
    .i_de_rd(deRd), .i_de_rd_we(deRdWe), .i_de_class(deClass), .i_wb_valid(wbValid), .i_wb_rd(wbRd),
    .o_stall(oStall[0]), .o_issue(oIssue[0]), .o_ex_fwd_rs1(oFwd1[0]), .o_ex_fwd_rs2(oFwd2[0]),
    .o_long_busy(oBusy[0]), .o_long_count(oCount[0]), .o_wb_err(oErr[0]));

  rapid_hazard_scoreboard #(.NUM_REGS(NUM_REGS), .MAX_LONG(MAX_LONG), .LOAD_USE_STALL(1'b0)) dutB (
    .i_clk(clk), .i_reset(rst), .i_advance(advance), .i_flush(flush), .i_de_valid(deValid),
    .i_de_rs1(deRs1), .i_de_rs1_used(deRs1Used), .i_de_rs2(deRs2), .i_de_rs2_used(deRs2Used),
    .i_de_rd(deRd), .i_de_rd_we(deRdWe), .i_de_class(deClass), .i_wb_valid(wbValid), .i_wb_rd(wbRd),
    .o_stall(oStall[1]), .o_issue(oIssue[1]), .o_ex_fwd_rs1(oFwd1[1]), .o_ex_fwd_rs2(oFwd2[1]),
    .o_long_busy(oBusy[1]), .o_long_count(oCount[1]), .o_wb_err(oErr[1]));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input int rs1, input logic u1, input int rs2,
                               input logic u2, input int rd, input logic we, input int cls,
                               input logic fl, input logic adv, input logic wbv, input int wbr);
    @(posedge clk);
    #1;
    deValid = v; deRs1 = REG_W'(rs1); deRs1Used = u1; deRs2 = REG_W'(rs2); deRs2Used = u2;
    deRd = REG_W'(rd); deRdWe = we; deClass = 2'(cls); flush = fl; advance = adv;
    wbValid = wbv; wbRd = REG_W'(wbr);
    #2;
  endtask

  task automatic applyIdle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < NUM_REGS; r++) mBusy[k][r] = 1'b0;
      mCnt[k] = 0; mExRd[k] = 0; mErr[k] = 0; mExValid[k] = 0; mExLoad[k] = 0;
      mFwd1[k] = 0; mFwd2[k] = 0;
    end
  endtask

  // Instance 0 stalls on load-use, instance 1 forwards load data
  function automatic bit modelStall(int k);
    bit m1   = deRs1Used && (deRs1 != 0);
    bit m2   = deRs2Used && (deRs2 != 0);
    bit raw1 = m1 && mBusy[k][deRs1] && !(wbValid && wbRd == deRs1);
    bit raw2 = m2 && mBusy[k][deRs2] && !(wbValid && wbRd == deRs2);
    bit lu   = (k == 0) && mExValid[k] && mExLoad[k] &&
               ((m1 && int'(deRs1) == mExRd[k]) || (m2 && int'(deRs2) == mExRd[k]));
    bit waw  = deRdWe && mBusy[k][deRd];
    bit full = (deClass == 2) && deRdWe && (mCnt[k] == MAX_LONG);
    return deValid && !flush && (raw1 || raw2 || lu || waw || full);
  endfunction

  function automatic bit modelIssue(int k);
    return deValid && !modelStall(k) && !flush && advance;
  endfunction

  task automatic modelStep(int k);
    bit iss  = modelIssue(k);
    bit m1   = deRs1Used && (deRs1 != 0);
    bit m2   = deRs2Used && (deRs2 != 0);
    bit wbOk = wbValid && (wbRd != 0) && mBusy[k][wbRd];
    if (advance) begin
      mFwd1[k]    = iss && m1 && mExValid[k] && (mExRd[k] == int'(deRs1));
      mFwd2[k]    = iss && m2 && mExValid[k] && (mExRd[k] == int'(deRs2));
      mExValid[k] = iss && deRdWe && (deRd != 0) && (deClass != 2);
      mExRd[k]    = int'(deRd);
      mExLoad[k]  = (deClass == 1);
    end
    if (wbValid) begin
      if (wbOk) begin
        mBusy[k][wbRd] = 1'b0;
        mCnt[k]--;
      end else begin
        mErr[k] = 1'b1;
      end
    end
    if (iss && deClass == 2 && deRdWe && deRd != 0) begin
      mBusy[k][deRd] = 1'b1;
      mCnt[k]++;
    end
  endtask

  // Every negedge: compare both instances against the model; every posedge: advance the model
  initial begin
    logic [31:0] expBusy;
    forever begin
      @(negedge clk);
      if (rst) modelReset();
      for (int k = 0; k < 2; k++) begin
        expBusy = '0;
        for (int r = 0; r < NUM_REGS; r++) expBusy[r] = mBusy[k][r];
        checkOutput($sformatf("stall[%0d]", k), 32'(oStall[k]), 32'(modelStall(k)));
        checkOutput($sformatf("issue[%0d]", k), 32'(oIssue[k]), 32'(modelIssue(k)));
        checkOutput($sformatf("fwd1[%0d]", k), 32'(oFwd1[k]), 32'(mFwd1[k]));
        checkOutput($sformatf("fwd2[%0d]", k), 32'(oFwd2[k]), 32'(mFwd2[k]));
        checkOutput($sformatf("busy[%0d]", k), oBusy[k], expBusy);
        checkOutput($sformatf("count[%0d]", k), 32'(oCount[k]), 32'(mCnt[k]));
        checkOutput($sformatf("wberr[%0d]", k), 32'(oErr[k]), 32'(mErr[k]));
      end
      @(posedge clk);
      if (!rst) for (int k = 0; k < 2; k++) modelStep(k);
    end
  end

  initial begin
    int cand[$];
    rst = 1'b1;
    deValid = 0; deRs1 = 0; deRs1Used = 0; deRs2 = 0; deRs2Used = 0; deRd = 0; deRdWe = 0;
    deClass = 0; flush = 0; advance = 0; wbValid = 0; wbRd = 0;
    repeat (2) @(posedge clk);
    #3;
    checkOutput("rst_stall", 32'(oStall[0]), 0);
    checkOutput("rst_count", 32'(oCount[0]), 0);
    checkOutput("rst_busy", oBusy[0], 0);
    checkOutput("rst_fwd1", 32'(oFwd1[0]), 0);
    checkOutput("rst_err", 32'(oErr[0]), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] ALU forwarding");
    applyStimulus(1, 0, 0, 0, 0, 5, 1, 0, 0, 1, 0, 0);
    applyStimulus(1, 5, 1, 6, 1, 8, 1, 0, 0, 1, 0, 0);
    checkOutput("alu_stall", 32'(oStall[0]), 0);
    checkOutput("alu_issue", 32'(oIssue[0]), 1);
    applyIdle();
    checkOutput("alu_fwd1", 32'(oFwd1[0]), 1);
    checkOutput("alu_fwd2", 32'(oFwd2[0]), 0);

    $display("[TB] load-use");
    applyStimulus(1, 0, 0, 0, 0, 7, 1, 1, 0, 1, 0, 0);
    applyStimulus(1, 7, 1, 0, 0, 10, 1, 0, 0, 1, 0, 0);
    checkOutput("lu_stallA", 32'(oStall[0]), 1);
    checkOutput("lu_issueA", 32'(oIssue[0]), 0);
    checkOutput("lu_stallB", 32'(oStall[1]), 0);
    applyStimulus(1, 7, 1, 0, 0, 10, 1, 0, 0, 1, 0, 0);
    checkOutput("lu_stallA2", 32'(oStall[0]), 0);
    checkOutput("lu_issueA2", 32'(oIssue[0]), 1);
    checkOutput("lu_fwdB", 32'(oFwd1[1]), 1);
    applyIdle();
    checkOutput("lu_fwdA", 32'(oFwd1[0]), 0);

    $display("[TB] long RAW");
    applyStimulus(1, 0, 0, 0, 0, 9, 1, 2, 0, 1, 0, 0);
    applyStimulus(1, 9, 1, 0, 0, 11, 1, 0, 0, 1, 0, 0);
    checkOutput("raw_stall", 32'(oStall[0]), 1);
    checkOutput("raw_busy", oBusy[0], 32'h0000_0200);
    checkOutput("raw_count", 32'(oCount[0]), 1);
    applyStimulus(1, 9, 1, 0, 0, 11, 1, 0, 0, 1, 1, 9);
    checkOutput("raw_wb_stall", 32'(oStall[0]), 0);
    checkOutput("raw_wb_issue", 32'(oIssue[0]), 1);
    applyIdle();
    checkOutput("raw_busy0", oBusy[0], 0);
    checkOutput("raw_count0", 32'(oCount[0]), 0);

    $display("[TB] long full");
    for (int r = 1; r <= 4; r++) applyStimulus(1, 0, 0, 0, 0, r, 1, 2, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 6, 1, 2, 0, 1, 0, 0);
    checkOutput("full_count", 32'(oCount[0]), 4);
    checkOutput("full_stall", 32'(oStall[0]), 1);
    applyStimulus(1, 0, 0, 0, 0, 6, 1, 2, 0, 1, 1, 2);
    checkOutput("full_wb_stall", 32'(oStall[0]), 1);
    applyStimulus(1, 0, 0, 0, 0, 6, 1, 2, 0, 1, 0, 0);
    checkOutput("full_issue", 32'(oIssue[0]), 1);
    checkOutput("full_count3", 32'(oCount[0]), 3);
    applyIdle();
    checkOutput("full_count4", 32'(oCount[0]), 4);
    checkOutput("full_busy", oBusy[0], 32'h0000_005A);

    $display("[TB] flush");
    applyStimulus(1, 1, 1, 0, 0, 13, 1, 1, 1, 1, 0, 0);
    checkOutput("fl_stall", 32'(oStall[0]), 0);
    checkOutput("fl_issue", 32'(oIssue[0]), 0);
    applyStimulus(1, 13, 1, 0, 0, 14, 1, 0, 0, 1, 0, 0);
    checkOutput("fl_bubble_stall", 32'(oStall[0]), 0);
    applyIdle();
    checkOutput("fl_fwd1", 32'(oFwd1[0]), 0);

    $display("[TB] writeback error");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 12);
    checkOutput("err_pre", 32'(oErr[0]), 0);
    applyIdle();
    checkOutput("err_set", 32'(oErr[0]), 1);
    applyIdle();
    checkOutput("err_sticky", 32'(oErr[0]), 1);

    $display("[TB] async reset");
    applyStimulus(1, 3, 1, 0, 0, 15, 1, 0, 0, 0, 0, 0);
    checkOutput("ar_stall_pre", 32'(oStall[0]), 1);
    rst = 1'b1;
    #1;
    checkOutput("ar_stall", 32'(oStall[0]), 0);
    checkOutput("ar_issue", 32'(oIssue[0]), 0);
    checkOutput("ar_busy", oBusy[0], 0);
    checkOutput("ar_count", 32'(oCount[0]), 0);
    checkOutput("ar_err", 32'(oErr[0]), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3);
    applyIdle();
    checkOutput("ar_late_wb_err", 32'(oErr[0]), 1);

    $display("[TB] random phase");
    for (int n = 0; n < 3000; n++) begin
      logic wbv;
      int wbr;
      cand.delete();
      for (int r = 1; r < 8; r++) if (mBusy[0][r] && mBusy[1][r]) cand.push_back(r);
      wbv = 1'b0;
      wbr = 0;
      if (cand.size() > 0 && $urandom_range(0, 3) == 0) begin
        wbv = 1'b1;
        wbr = cand[$urandom_range(0, cand.size() - 1)];
      end else if ($urandom_range(0, 99) == 0) begin
        wbv = 1'b1;
        wbr = $urandom_range(0, 7);
      end
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
                    $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 7) == 0,
                    $urandom_range(0, 3) != 0, wbv, wbr);
    end
    applyIdle();
    @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
